// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a multi-cycle load/store port.
// A request is accepted in IDLE, waits a fixed latency in WAIT, then
// completes in RESP. On the RESP edge the load result is registered, or the
// store is committed to the word RAM with byte/halfword lane steering.
// o_ready is a one-cycle pulse that follows that edge.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When it is defined,
// misaligned half/word accesses are suppressed and flagged on o_misaligned.
// When it is undefined, the offending low address bits are forced to zero.
module dmem_responder #(
    parameter int DEPTH     = 1024,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_misaligned
);

    localparam int AW     = $clog2(DEPTH);
    localparam int MAXLAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W  = (MAXLAT > 1) ? $clog2(MAXLAT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [AW+1:0]     addr_q;
    logic [31:0]       wdata_q;
    logic              ready_q;
    logic [31:0]       rdata_q;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_word_q;

    logic [AW-1:0]     idx_d;
    logic [1:0]        lane_d;
    logic [7:0]        byte_sel_d;
    logic [15:0]       half_sel_d;
    logic [31:0]       load_result_d;
    logic [3:0]        be_d;
    logic [31:0]       wlane_d;

    // Bits above the RAM index are ignored, so addresses wrap modulo the RAM size.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^i_addr[31:AW+2];

    assign idx_d = addr_q[AW+1:2];

    // Effective byte lane: half and word accesses are aligned down.
    // In trap mode a misaligned access is suppressed instead, so the
    // aligned-down lane never reaches the RAM or the result.
    always_comb begin
        lane_d = addr_q[1:0];
        case (funct3_q[1:0])
            2'b01:   lane_d = {addr_q[1], 1'b0};
            2'b10:   lane_d = 2'b00;
            default: lane_d = addr_q[1:0];
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned_d;
    logic misaligned_q;

    // Misalignment decode for LH/LHU/SH (odd address) and LW/SW (non-word address).
    always_comb begin
        misaligned_d = 1'b0;
        case (funct3_q)
            3'b001:  misaligned_d = addr_q[0];
            3'b101:  misaligned_d = !we_q && addr_q[0];
            3'b010:  misaligned_d = |addr_q[1:0];
            default: misaligned_d = 1'b0;
        endcase
    end

    assign o_misaligned = misaligned_q;
`else
    assign o_misaligned = 1'b0;
`endif

    // Load extraction with RV32I sign/zero extension.
    always_comb begin
        byte_sel_d    = rd_word_q[{lane_d, 3'b000} +: 8];
        half_sel_d    = lane_d[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        load_result_d = 32'h0;
        case (funct3_q)
            3'b000:  load_result_d = {{24{byte_sel_d[7]}}, byte_sel_d};
            3'b100:  load_result_d = {24'h0, byte_sel_d};
            3'b001:  load_result_d = {{16{half_sel_d[15]}}, half_sel_d};
            3'b101:  load_result_d = {16'h0, half_sel_d};
            3'b010:  load_result_d = rd_word_q;
            default: load_result_d = 32'h0;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        if (misaligned_d) begin
            load_result_d = 32'h0;
        end
`endif
    end

    // Store byte enables; unsupported store widths write nothing.
    always_comb begin
        be_d = 4'b0000;
        if (we_q) begin
            case (funct3_q)
                3'b000:  be_d = 4'b0001 << lane_d;
                3'b001:  be_d = lane_d[1] ? 4'b1100 : 4'b0011;
                3'b010:  be_d = 4'b1111;
                default: be_d = 4'b0000;
            endcase
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        if (misaligned_d) begin
            be_d = 4'b0000;
        end
`endif
    end

    // Per-lane store data: a byte is replicated to every lane, a half to both
    // halves, and a word passes straight through. be_d picks the live lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
            assign wlane_d[gi*8 +: 8] =
                (funct3_q[1:0] == 2'b00) ? wdata_q[7:0] :
                (funct3_q[1:0] == 2'b01) ? wdata_q[(gi % 2)*8 +: 8] :
                                           wdata_q[gi*8 +: 8];
        end
    endgenerate

    // Word RAM: byte-enabled write on the RESP edge unless reset is asserted;
    // the registered read tracks the captured address every cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst && state_q == S_RESP) begin
            for (int b = 0; b < 4; b++) begin
                if (be_d[b]) begin
                    mem[idx_d][b*8 +: 8] <= wlane_d[b*8 +: 8];
                end
            end
        end
        rd_word_q <= mem[idx_d];
    end

    // Transaction FSM with registered completion outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (i_req) begin
                        we_q     <= i_we;
                        funct3_q <= i_funct3;
                        addr_q   <= i_addr[AW+1:0];
                        wdata_q  <= i_wdata;
                        cnt_q    <= i_we ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    ready_q <= 1'b1;
                    if (!we_q) begin
                        rdata_q <= load_result_d;
                    end
`ifdef DMEM_MISALIGN_TRAP_EN
                    misaligned_q <= misaligned_d;
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_rdata = rdata_q;
    assign o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (default parameters).
// Compile with +define+DMEM_MISALIGN_TRAP_EN to exercise the trap variant.
module tb_dmem_responder;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic        o_ready;
    logic [31:0] o_rdata;
    logic        o_busy;
    logic        o_misaligned;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_hold = 32'h0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    dmem_responder dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_we         (i_we),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_ready      (o_ready),
        .o_rdata      (o_rdata),
        .o_busy       (o_busy),
        .o_misaligned (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One access, started just after a clock edge. lat counts edges after the
    // accept edge until o_ready is seen (-1 if it never arrives).
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                          output int lat, output int busy);
        bit seen = 0;
        int edges = 0;
        busy = 0;
        rd = 32'h0;
        mis = 1'b0;
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge i_clk); #1;
            edges++;
            if (o_busy) busy++;
            if (o_ready) begin
                seen = 1;
                rd = o_rdata;
                mis = o_misaligned;
            end
        end
        i_req = 1'b0;
        lat = seen ? edges - 1 : -1;
        $display("txn we=%0d f3=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h mis=%0d lat=%0d busy=%0d",
                 we, f3, addr, wd, rd, mis, lat, busy);
        @(posedge i_clk); #1;
        check_eq("ready_width", {31'h0, o_ready}, 32'h0);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_mis);
        logic [31:0] rd;
        logic mis;
        int lat, busy;
        access(1'b0, f3, addr, 32'h0, rd, mis, lat, busy);
        check_eq({tag, ".lat"}, lat, 32'd3);
        check_eq({tag, ".data"}, rd, exp_data);
        check_eq({tag, ".mis"}, {31'h0, mis}, {31'h0, exp_mis});
        exp_hold = exp_data;
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic exp_mis);
        logic [31:0] rd;
        logic mis;
        int lat, busy;
        access(1'b1, f3, addr, wd, rd, mis, lat, busy);
        check_eq({tag, ".lat"}, lat, 32'd2);
        check_eq({tag, ".hold"}, rd, exp_hold);
        check_eq({tag, ".mis"}, {31'h0, mis}, {31'h0, exp_mis});
    endtask

    initial begin
        logic [31:0] rd;
        logic mis;
        int lat, busy, pulses, last_pulse, cnt;
        logic prev_ready;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("rst.ready", {31'h0, o_ready}, 32'h0);
        check_eq("rst.rdata", o_rdata, 32'h0);
        check_eq("rst.busy", {31'h0, o_busy}, 32'h0);
        check_eq("rst.mis", {31'h0, o_misaligned}, 32'h0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Basic SW then LW with latency and busy duration
        access(1'b1, F_W, 32'h10, 32'hDEADBEEF, rd, mis, lat, busy);
        check_eq("sw10.lat", lat, 32'd2);
        check_eq("sw10.busy", busy, 32'd2);
        check_eq("sw10.hold", rd, 32'h0);
        access(1'b0, F_W, 32'h10, 32'h0, rd, mis, lat, busy);
        check_eq("lw10.lat", lat, 32'd3);
        check_eq("lw10.busy", busy, 32'd3);
        check_eq("lw10.data", rd, 32'hDEADBEEF);
        exp_hold = 32'hDEADBEEF;

        // Sub-word loads from 0x80FF7F01
        do_store("sw10b", F_W, 32'h10, 32'h80FF7F01, 1'b0);
        do_load("lb11", F_B, 32'h11, 32'h0000007F, 1'b0);
        do_load("lb12", F_B, 32'h12, 32'hFFFFFFFF, 1'b0);
        do_load("lbu13", F_BU, 32'h13, 32'h00000080, 1'b0);
        do_load("lh12", F_H, 32'h12, 32'hFFFF80FF, 1'b0);
        do_load("lhu10", F_HU, 32'h10, 32'h00007F01, 1'b0);
        do_load("ld011", 3'b011, 32'h10, 32'h0, 1'b0);
        do_load("wrap", F_W, 32'h80001010, 32'h80FF7F01, 1'b0);
        do_store("st011", 3'b011, 32'h10, 32'h0, 1'b0);
        do_load("lw10c", F_W, 32'h10, 32'h80FF7F01, 1'b0);

        // Sub-word stores
        do_store("sw20", F_W, 32'h20, 32'h11223344, 1'b0);
        do_store("sb21", F_B, 32'h21, 32'h000000AA, 1'b0);
        do_load("lw20a", F_W, 32'h20, 32'h1122AA44, 1'b0);
        do_store("sh22", F_H, 32'h22, 32'h00005555, 1'b0);
        do_load("lw20b", F_W, 32'h20, 32'h5555AA44, 1'b0);

        // Back-to-back loads with i_req held; garbage inputs while busy
        i_req = 1'b1; i_we = 1'b0; i_funct3 = F_W; i_addr = 32'h10; i_wdata = 32'h0;
        pulses = 0; last_pulse = -1; prev_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge i_clk); #1;
            if (o_ready) begin
                pulses++;
                check_eq("b2b.data", o_rdata, 32'h80FF7F01);
                check_eq("b2b.width", {31'h0, prev_ready}, 32'h0);
                if (last_pulse >= 0) check_eq("b2b.gap", k - last_pulse, 32'd4);
                last_pulse = k;
                $display("txn b2b pulse=%0d edge=%0d rdata=0x%08h", pulses, k, o_rdata);
            end
            prev_ready = o_ready;
            if (pulses >= 3) i_req = 1'b0;
            if (o_busy) begin
                i_we = 1'b1; i_funct3 = F_B; i_addr = 32'h24; i_wdata = 32'hFFFFFFFF;
            end else begin
                i_we = 1'b0; i_funct3 = F_W; i_addr = 32'h10; i_wdata = 32'h0;
            end
        end
        i_req = 1'b0;
        check_eq("b2b.count", pulses, 32'd3);
        exp_hold = 32'h80FF7F01;
        do_load("lw20c", F_W, 32'h20, 32'h5555AA44, 1'b0);

        // Store aborted by reset during WAIT
        do_store("sw30", F_W, 32'h30, 32'hCAFEF00D, 1'b0);
        do_load("lw30a", F_W, 32'h30, 32'hCAFEF00D, 1'b0);
        i_req = 1'b1; i_we = 1'b1; i_funct3 = F_W; i_addr = 32'h30; i_wdata = 32'h12345678;
        @(posedge i_clk); #1;
        check_eq("abort.accept", {31'h0, o_busy}, 32'h1);
        i_req = 1'b0; i_rst = 1'b1;
        @(posedge i_clk); #1;
        check_eq("abort.ready", {31'h0, o_ready}, 32'h0);
        check_eq("abort.rdata", o_rdata, 32'h0);
        check_eq("abort.busy", {31'h0, o_busy}, 32'h0);
        check_eq("abort.mis", {31'h0, o_misaligned}, 32'h0);
        i_rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            if (o_ready) cnt++;
        end
        check_eq("abort.noready", cnt, 32'd0);
        $display("txn abort sw 0x30 by reset");
        exp_hold = 32'h0;
        do_load("lw30b", F_W, 32'h30, 32'hCAFEF00D, 1'b0);

        // Misaligned accesses
        do_load("lb31", F_B, 32'h31, 32'hFFFFFFF0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        do_load("lw31", F_W, 32'h31, 32'h0, 1'b1);
        do_load("lh33", F_H, 32'h33, 32'h0, 1'b1);
        do_load("lhu31", F_HU, 32'h31, 32'h0, 1'b1);
        do_store("sw33", F_W, 32'h33, 32'h0BADCAFE, 1'b1);
        do_load("lw30c", F_W, 32'h30, 32'hCAFEF00D, 1'b0);
`else
        do_load("lw31", F_W, 32'h31, 32'hCAFEF00D, 1'b0);
        do_load("lh33", F_H, 32'h33, 32'hFFFFCAFE, 1'b0);
        do_load("lhu31", F_HU, 32'h31, 32'h0000F00D, 1'b0);
        do_store("sw33", F_W, 32'h33, 32'h0BADCAFE, 1'b0);
        do_load("lw30c", F_W, 32'h30, 32'h0BADCAFE, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory side of the core's multi-cycle load/store interface.
- The core raises a request and holds it until this block returns a one-cycle o_ready. The core keeps PC/register write stalled until then.
- Contains a word-organised RAM, a latency counter, and byte/halfword lane steering with RV32I funct3 semantics (LB/LH/LW/LBU/LHU, SB/SH/SW).

Parameters:
- DEPTH, 1024: number of 32-bit words; power of two.
- READ_LAT, 2: cycles from request accept to o_ready for loads; >=1.
- WRITE_LAT, 1: cycles from request accept to o_ready for stores; >=1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  access request; held by core until o_ready.
- i_we  in  1  1 = store, 0 = load; valid with i_req.
- i_funct3  in  3  RV32I width/sign code.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_ready  out  1  one-cycle completion pulse.
- o_rdata  out  32  load result, sign/zero-extended; valid when o_ready=1.
- o_busy  out  1  1 while a transaction is in flight (states WAIT, RESP).
- o_misaligned  out  1  misalignment flag; see Optional Feature.

Behaviour:
- Reset: state IDLE, counter 0, o_ready=0, o_rdata=0, o_busy=0, o_misaligned=0. RAM contents are not reset. i_rst has priority over everything, including mid-transaction: an in-flight transaction is abandoned, and a store not yet committed is never written.
- State IDLE:
  - i_req is sampled only in IDLE.
  - On i_req=1, capture i_we, i_funct3, i_addr, i_wdata.
  - Load counter with (i_we ? WRITE_LAT : READ_LAT) - 1, then go to WAIT.
- State WAIT:
  - Input changes are ignored; the captured values are used.
  - Decrement counter; when counter==0, go to RESP.
- State RESP (one cycle):
  - o_ready=1 registered.
  - Load: o_rdata = extracted value.
  - Store: RAM written on this edge; o_rdata holds its previous value.
  - Next state is IDLE unconditionally. An i_req still high in that IDLE cycle starts a new transaction, so back-to-back accesses have at least one IDLE cycle between them.
- Latency: o_ready asserts exactly LAT+1 cycles after the i_req accept edge (READ_LAT=2 → 3rd edge after accept).
- Indexing: word index = addr[log2(DEPTH)+1:2]; upper bits ignored, so addresses wrap modulo 4*DEPTH bytes.
- Loads (lane = addr[1:0]):
  - LB (000): byte at lane, sign-extended.
  - LBU (100): byte at lane, zero-extended.
  - LH (001): half at addr[1], sign-extended.
  - LHU (101): half at addr[1], zero-extended.
  - LW (010): full word.
  - funct3 011/110/111: result 0.
- Stores:
  - SB (000): writes byte lane only, from i_wdata[7:0].
  - SH (001): writes half lane only, from i_wdata[15:0].
  - SW (010): writes full word.
  - Other funct3 values: no write, o_ready still pulses.
- o_rdata holds its last value outside RESP.
- A load to the same word immediately after a store returns the new data; the write commits in RESP, before the next accept.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Misaligned store: no write.
  - Misaligned load: o_rdata=0.
  - o_misaligned=1 coincident with o_ready; 0 otherwise.
  - Latency unchanged.
- Undefined:
  - Offending low address bits are forced to 0 (access aligned down); the access completes normally.
  - o_misaligned tied 0.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → o_ready on 2nd edge for the store and 3rd edge for the load; o_rdata=0xDEADBEEF; o_busy high for 2 and 3 cycles respectively.
- With word 0x10 = 0x80FF7F01:
  - LB 0x11 → 0x0000007F.
  - LB 0x12 → 0xFFFFFFFF.
  - LBU 0x13 → 0x00000080.
  - LH 0x12 → 0xFFFF80FF.
  - LHU 0x10 → 0x00007F01.
- SB 0x21 data 0x000000AA onto word 0x11223344, then LW 0x20 → 0x1122AA44; SH 0x22 data 0x5555 → 0x5555AA44.
- i_req held high across 3 loads → exactly 3 o_ready pulses, each one cycle wide, separated by one IDLE cycle; input changes during WAIT do not alter the result.
- SW 0x30 0x12345678 with i_rst pulsed during WAIT, then LW 0x30 → previous contents; no o_ready from the aborted access; all outputs 0 after reset.
- DMEM_MISALIGN_TRAP_EN defined: LW 0x31 → o_rdata=0, o_misaligned=1 with o_ready. Undefined: LW 0x31 returns word 0x30 and o_misaligned=0.
